wav_ddr_responder: RTL and testbench

// - Responder side of the toggle-handshake sample-ROM interface used by the WAV player (s_rd/s_addr -> s_dout/s_ack).
// - Serves 64-bit word reads from DDR3 through a one-word cache.
// - Packs byte-wide ioctl download writes (index 2) into 64-bit masked DDR3 writes.
// - Sits between hps_io/wave_sound and the DDRAM_* top-level pins; runs entirely on clk_sys (DDRAM_CLK = clk_sys).

---
 rtl/wav_ddr_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_wav_ddr_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wav_ddr_responder.sv
// rtl/wav_ddr_responder.sv - toggle-handshake sample-ROM responder over DDR3 with byte-packing download writer
// Optional WAV_PREFETCH_EN: two-line cache, BURSTCNT=2 misses and next-word prefetch.
module wav_ddr_responder #(
  parameter logic [28:0] BASE_ADDR = 29'h0300000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        s_rd,
  input  logic [24:0] s_addr,
  output logic [63:0] s_dout,
  output logic        s_ack,
  input  logic        wr_en,
  input  logic [27:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        wr_flush,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;
  state_t state;

  logic [24:0] c_tag, rd_tag;
  logic [63:0] c_data;
  logic        c_valid;

  logic [63:0] wbuf_data;
  logic [7:0]  wbuf_be;
  logic [24:0] wbuf_tag;
  logic        wr_lock, flush_req;
  logic        skid_valid;
  logic [27:0] skid_addr;
  logic [7:0]  skid_data;

  logic        in_v, byte_store, req, hit1, inval1;
  logic [27:0] in_addr;
  logic [7:0]  in_data, be_next;

`ifdef WAV_PREFETCH_EN
  logic [24:0] c2_tag, pf_tag;
  logic [63:0] c2_data;
  logic        c2_valid, pf_pending, pf_fill, second_beat, hit2, inval2;
`endif

  // A held skid byte is always consumed before a fresh strobe.
  always_comb begin
    in_v       = skid_valid | wr_en;
    in_addr    = skid_valid ? skid_addr : wr_addr;
    in_data    = skid_valid ? skid_data : wr_data;
    be_next    = wbuf_be | (8'd1 << in_addr[2:0]);
    byte_store = !wr_lock && in_v && !(wbuf_be != 8'd0 && in_addr[27:3] != wbuf_tag);
    req        = s_rd != s_ack;
    inval1     = byte_store && c_valid && c_tag == in_addr[27:3];
    hit1       = c_valid && c_tag == s_addr && !(byte_store && in_addr[27:3] == s_addr);
`ifdef WAV_PREFETCH_EN
    inval2     = byte_store && c2_valid && c2_tag == in_addr[27:3];
    hit2       = c2_valid && c2_tag == s_addr && !(byte_store && in_addr[27:3] == s_addr);
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= IDLE;
      s_ack          <= s_rd;
      s_dout         <= '0;
      DDRAM_RD       <= 1'b0;
      DDRAM_WE       <= 1'b0;
      DDRAM_BE       <= '0;
      DDRAM_BURSTCNT <= 8'd1;
      DDRAM_ADDR     <= '0;
      DDRAM_DIN      <= '0;
      c_valid        <= 1'b0;
      c_tag          <= '0;
      c_data         <= '0;
      rd_tag         <= '0;
      wbuf_data      <= '0;
      wbuf_be        <= '0;
      wbuf_tag       <= '0;
      wr_lock        <= 1'b0;
      flush_req      <= 1'b0;
      skid_valid     <= 1'b0;
      skid_addr      <= '0;
      skid_data      <= '0;
`ifdef WAV_PREFETCH_EN
      c2_valid       <= 1'b0;
      c2_tag         <= '0;
      c2_data        <= '0;
      pf_tag         <= '0;
      pf_pending     <= 1'b0;
      pf_fill        <= 1'b0;
      second_beat    <= 1'b0;
`endif
    end else begin
      // Write packing; wr_lock freezes the buffer until the DDR write is accepted.
      if (!wr_lock) begin
        if (byte_store) begin
          wbuf_data[{in_addr[2:0], 3'b000} +: 8] <= in_data;
          wbuf_be    <= be_next;
          wbuf_tag   <= in_addr[27:3];
          if (be_next == 8'hFF) wr_lock <= 1'b1;
          skid_valid <= skid_valid & wr_en;
          if (skid_valid & wr_en) begin
            skid_addr <= wr_addr;
            skid_data <= wr_data;
          end
        end else if (in_v) begin
          wr_lock    <= 1'b1;
          skid_valid <= 1'b1;
          if (!skid_valid) begin
            skid_addr <= wr_addr;
            skid_data <= wr_data;
          end
        end else if ((flush_req || wr_flush) && wbuf_be != 8'd0) begin
          wr_lock <= 1'b1;
        end
      end else if (wr_en) begin
        skid_valid <= 1'b1;
        skid_addr  <= wr_addr;
        skid_data  <= wr_data;
      end

      if (wr_flush) flush_req <= 1'b1;
      else if (!wr_lock && !in_v) flush_req <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_lock) begin
            state          <= WR_ISSUE;
            DDRAM_WE       <= 1'b1;
            DDRAM_ADDR     <= BASE_ADDR + {4'd0, wbuf_tag};
            DDRAM_DIN      <= wbuf_data;
            DDRAM_BE       <= wbuf_be;
            DDRAM_BURSTCNT <= 8'd1;
          end else if (req && hit1) begin
            s_dout <= c_data;
            s_ack  <= s_rd;
          end
`ifdef WAV_PREFETCH_EN
          else if (req && hit2) begin
            s_dout     <= c2_data;
            s_ack      <= s_rd;
            c_tag      <= c2_tag;
            c_data     <= c2_data;
            c_valid    <= 1'b1;
            c2_valid   <= 1'b0;
            pf_pending <= 1'b1;
            pf_tag     <= c2_tag + 25'd1;
          end
`endif
          else if (req) begin
            state      <= RD_ISSUE;
            DDRAM_RD   <= 1'b1;
            DDRAM_ADDR <= BASE_ADDR + {4'd0, s_addr};
            rd_tag     <= s_addr;
`ifdef WAV_PREFETCH_EN
            DDRAM_BURSTCNT <= 8'd2;
            pf_fill        <= 1'b0;
            pf_pending     <= 1'b0;
            second_beat    <= 1'b0;
`else
            DDRAM_BURSTCNT <= 8'd1;
`endif
          end
`ifdef WAV_PREFETCH_EN
          else if (pf_pending) begin
            state          <= RD_ISSUE;
            DDRAM_RD       <= 1'b1;
            DDRAM_ADDR     <= BASE_ADDR + {4'd0, pf_tag};
            DDRAM_BURSTCNT <= 8'd1;
            rd_tag         <= pf_tag;
            pf_fill        <= 1'b1;
            pf_pending     <= 1'b0;
          end
`endif
        end
        WR_ISSUE: if (!DDRAM_BUSY) begin
          DDRAM_WE  <= 1'b0;
          wbuf_be   <= '0;
          wbuf_data <= '0;
          wr_lock   <= 1'b0;
          state     <= IDLE;
        end
        RD_ISSUE: if (!DDRAM_BUSY) begin
          DDRAM_RD <= 1'b0;
          state    <= RD_WAIT;
        end
        RD_WAIT: if (DDRAM_DOUT_READY) begin
`ifdef WAV_PREFETCH_EN
          if (pf_fill || second_beat) begin
            c2_data     <= DDRAM_DOUT;
            c2_tag      <= pf_fill ? rd_tag : rd_tag + 25'd1;
            c2_valid    <= 1'b1;
            second_beat <= 1'b0;
            state       <= IDLE;
          end else begin
            c_data      <= DDRAM_DOUT;
            c_tag       <= rd_tag;
            c_valid     <= 1'b1;
            s_dout      <= DDRAM_DOUT;
            s_ack       <= s_rd;
            second_beat <= 1'b1;
          end
`else
          c_data  <= DDRAM_DOUT;
          c_tag   <= rd_tag;
          c_valid <= 1'b1;
          s_dout  <= DDRAM_DOUT;
          s_ack   <= s_rd;
          state   <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase

      if (inval1) c_valid <= 1'b0;
`ifdef WAV_PREFETCH_EN
      if (inval2) c2_valid <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_wav_ddr_responder.sv
// tb/tb_wav_ddr_responder.sv - directed self-checking bench for wav_ddr_responder
module tb_wav_ddr_responder;
  localparam logic [28:0] BASE = 29'h0300000;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        s_rd = 1'b0;
  logic [24:0] s_addr = '0;
  logic [63:0] s_dout;
  logic        s_ack;
  logic        wr_en = 1'b0;
  logic [27:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_flush = 1'b0;
  logic        busy = 1'b0;
  logic [7:0]  burstcnt;
  logic [28:0] ddr_addr;
  logic [63:0] ddr_dout = '0;
  logic        rdy = 1'b0;
  logic        ddr_rd;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_be;
  logic        ddr_we;

  wav_ddr_responder dut (
    .clk_sys(clk_sys), .reset(reset), .s_rd(s_rd), .s_addr(s_addr),
    .s_dout(s_dout), .s_ack(s_ack), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_flush(wr_flush), .DDRAM_BUSY(busy),
    .DDRAM_BURSTCNT(burstcnt), .DDRAM_ADDR(ddr_addr), .DDRAM_DOUT(ddr_dout),
    .DDRAM_DOUT_READY(rdy), .DDRAM_RD(ddr_rd), .DDRAM_DIN(ddr_din),
    .DDRAM_BE(ddr_be), .DDRAM_WE(ddr_we)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  int rd_hi = 0;
  int hi0, rc0;
  logic [63:0] w_din;
  logic [7:0]  w_be;
  logic [28:0] w_addr, r_addr;

  // Bus observer: records each accepted DDR command.
  always @(posedge clk_sys) begin
    if (ddr_rd) rd_hi++;
    if (ddr_we && !busy) begin
      we_cnt++;
      w_din  = ddr_din;
      w_be   = ddr_be;
      w_addr = ddr_addr;
    end
    if (ddr_rd && !busy) begin
      rd_cnt++;
      r_addr = ddr_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [27:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ack", s_ack, 0);
    check("rst_dout", s_dout, 0);
    check("rst_rd", ddr_rd, 0);
    check("rst_we", ddr_we, 0);
    check("rst_be", ddr_be, 0);
    check("rst_burst", burstcnt, 1);

    // Full word of bytes
    for (int i = 0; i < 8; i++) wr_byte(28'(i), 8'((i + 1) * 17));
    repeat (4) tick();
    check("full_we_cnt", we_cnt, 1);
    check("full_din", w_din, 64'h8877665544332211);
    check("full_be", w_be, 8'hFF);
    check("full_addr", w_addr, BASE);

    // Partial word committed by wr_flush
    wr_byte(28'd5, 8'hA5);
    wr_byte(28'd6, 8'hB6);
    wr_flush = 1'b1;
    tick();
    wr_flush = 1'b0;
    repeat (8) tick();
    check("part_we_cnt", we_cnt, 2);
    check("part_be", w_be, 8'h60);
    check("part_din", w_din, 64'h00B6A50000000000);
    check("part_addr", w_addr, BASE);

    // Tag change flushes the old word, new byte waits in the skid register
    wr_byte(28'd8, 8'hC8);
    wr_byte(28'd16, 8'hD0);
    repeat (4) tick();
    check("tag_we_cnt", we_cnt, 3);
    check("tag_din", w_din, 64'hC8);
    check("tag_be", w_be, 8'h01);
    check("tag_addr", w_addr, BASE + 29'd1);
    wr_flush = 1'b1;
    tick();
    wr_flush = 1'b0;
    repeat (4) tick();
    check("skid_we_cnt", we_cnt, 4);
    check("skid_din", w_din, 64'hD0);
    check("skid_addr", w_addr, BASE + 29'd2);

    // Read miss with 4 busy cycles, data 10 cycles after accept
    hi0 = rd_hi;
    rc0 = rd_cnt;
    s_addr = 25'd3;
    busy = 1'b1;
    s_rd = 1'b1;
    tick();
    check("miss_rd_up", ddr_rd, 1);
    repeat (4) tick();
    busy = 1'b0;
    tick();
    check("miss_rd_down", ddr_rd, 0);
    check("miss_rd_cycles", rd_hi - hi0, 5);
    check("miss_rd_cnt", rd_cnt - rc0, 1);
    check("miss_addr", r_addr, BASE + 29'd3);
    check("miss_burst", burstcnt, 1);
    repeat (9) tick();
    check("miss_no_early_ack", s_ack, 0);
    ddr_dout = 64'hDEADBEEF01234567;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("miss_ack", s_ack, 1);
    check("miss_dout", s_dout, 64'hDEADBEEF01234567);

    // Hit: ack after one cycle, no DDR read
    rc0 = rd_cnt;
    ddr_dout = '0;
    s_rd = 1'b0;
    tick();
    check("hit_ack", s_ack, 0);
    check("hit_dout", s_dout, 64'hDEADBEEF01234567);
    check("hit_no_rd", ddr_rd, 0);
    check("hit_rd_cnt", rd_cnt - rc0, 0);

    // Byte write to word 3 invalidates the cache
    wr_byte(28'd24, 8'h5A);
    s_rd = 1'b1;
    tick();
    check("inval_reread", ddr_rd, 1);
    tick();
    ddr_dout = 64'h0F0E0D0C0B0A0908;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("inval_ack", s_ack, 1);
    check("inval_dout", s_dout, 64'h0F0E0D0C0B0A0908);

    // Pending flush wins over a read toggle
    wr_flush = 1'b1;
    tick();
    wr_flush = 1'b0;
    s_addr = 25'd7;
    s_rd = 1'b0;
    tick();
    check("prio_we", ddr_we, 1);
    check("prio_no_rd", ddr_rd, 0);
    tick();
    tick();
    check("prio_rd_after", ddr_rd, 1);
    check("prio_din", w_din, 64'h5A);
    check("prio_be", w_be, 8'h01);
    check("prio_waddr", w_addr, BASE + 29'd3);
    tick();

    // Reset in RD_WAIT abandons the request
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_ack_eq_rd", s_ack, 0);
    ddr_dout = 64'hFFFFFFFFFFFFFFFF;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
    check("rst2_no_ack", s_ack, 0);
    check("rst2_dout", s_dout, 0);
    check("rst2_no_rd", ddr_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
